pdp_eaddr_unit: RTL and testbench
=================================

Name: pdp_eaddr_unit

Overview:
- Effective-address sequencer for the 12-bit PDP-style processor; sits between the instruction decode/control path and the 4096x12 synchronous memory.
- Decodes page/zero and indirect bits of a memory-reference instruction, performs the indirect pointer fetch, and performs auto-index increment/write-back for locations 0o010-0o017.
- Delivers the final 12-bit effective address with a done pulse.
- Drives the memory's mem_read/mem_write/address/write_data and consumes its registered read_data, which has 1-cycle latency.

Parameters:
- AUTO_LO, 12'o0010, lowest auto-index address (inclusive).
- AUTO_HI, 12'o0017, highest auto-index address (inclusive).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- instr  in  12  instruction; fields opcode[11:9], I[8], Z[7], offset[6:0].
- pc  in  12  address of current instruction; supplies page bits.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; eaddr/no_mem valid.
- eaddr  out  12  effective address, held until next accepted start.
- no_mem  out  1  set when accepted opcode is 6 or 7.
- mem_read  out  1  read strobe to memory.
- mem_write  out  1  write strobe to memory.
- mem_address  out  12  memory address.
- mem_write_data  out  12  memory write data.
- mem_read_data  in  12  registered memory output, valid the cycle after mem_read.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, no_mem, mem_read and mem_write = 0; eaddr, mem_address and mem_write_data = 0. Strobes fall immediately, not at the next edge.
- Instruction, pc and derived direct address are latched at start acceptance; later input changes are ignored.
- Direct address: Z=1 -> direct={pc[11:7], offset}; Z=0 -> direct={5'b0, offset}.
- States: IDLE, RD, CAP, WB, DONE.
- IDLE + start, opcode 6/7 -> DONE; no_mem=1; eaddr=0; no memory strobe.
- IDLE + start, I=0 -> DONE; eaddr=direct; no_mem=0.
- IDLE + start, I=1 -> RD.
- RD: mem_read=1, mem_address=direct -> CAP.
- CAP: ptr<=mem_read_data. If AUTO_LO<=direct<=AUTO_HI -> WB, else eaddr<=mem_read_data -> DONE.
- WB: mem_write=1, mem_address=direct, mem_write_data=ptr+1 (mod 4096, so 12'o7777 wraps to 0) -> DONE, eaddr<=ptr+1.
- DONE: done=1 for exactly one cycle -> IDLE.
- Latency, start-sampling edge to done high: direct and opcode 6/7 = 1 cycle; indirect = 3 cycles; auto-index = 4 cycles.
- mem_read and mem_write are never high together; both are 0 in IDLE, CAP and DONE.
- start is ignored while busy=1, including in DONE; no queuing.
- Auto-index applies only when I=1. A direct (I=0) reference to 0o010-0o017 is a plain access.
- Reset in RD/CAP: no write issued. Reset in WB: the write is aborted if asserted before the WB edge.

Test Plan:
- pc=12'o4321, instr=12'o1205, start -> 1 cycle later done=1, eaddr=12'o4205, no_mem=0, no mem strobes.
- instr=12'o5420, mem[12'o0020]=12'o3456 -> mem_read with address 12'o0020 one cycle after start; done 3 cycles after start; eaddr=12'o3456; mem_write never high.
- instr=12'o1410, mem[12'o0010]=12'o0777 -> write of 12'o1000 to 12'o0010; done 4 cycles after start; eaddr=12'o1000.
- instr=12'o1417, mem[12'o0017]=12'o7777 -> mem[12'o0017] becomes 0; eaddr=0.
- instr=12'o7402 -> done after 1 cycle, no_mem=1, eaddr=0; second start pulsed during DONE is ignored.
- instr=12'o1410, rst asserted mid-RD -> mem_read and busy fall immediately, no done, mem[12'o0010] unchanged; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/pdp_eaddr_unit.sv
// pdp_eaddr_unit
// Effective-address sequencer for the 12-bit PDP-style processor.
// Decodes the Z (page) and I (indirect) bits of a memory-reference instruction,
// fetches the indirect pointer, and increments/writes back auto-index pointers
// that live in AUTO_LO..AUTO_HI. The final address is delivered with a done pulse.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            request, sampled only while idle
//   instr, pc        instruction and its address, latched when start is accepted
//   busy             high whenever the sequencer is not idle
//   done             one-cycle pulse; eaddr/no_mem are valid
//   eaddr            effective address, held until the next accepted start
//   no_mem           accepted opcode was 6 or 7 (not a memory reference)
//   mem_read         read strobe to memory
//   mem_write        write strobe to memory
//   mem_address      memory address
//   mem_write_data   memory write data
//   mem_read_data    registered memory output, valid the cycle after mem_read
module pdp_eaddr_unit #(
    parameter logic [11:0] AUTO_LO = 12'o0010,
    parameter logic [11:0] AUTO_HI = 12'o0017
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] instr,
    input  logic [11:0] pc,
    output logic        busy,
    output logic        done,
    output logic [11:0] eaddr,
    output logic        no_mem,
    output logic        mem_read,
    output logic        mem_write,
    output logic [11:0] mem_address,
    output logic [11:0] mem_write_data,
    input  logic [11:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WB,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] direct_q, direct_d;
    logic [11:0] ptr_q, ptr_d;
    logic [11:0] eaddr_q, eaddr_d;
    logic        no_mem_q, no_mem_d;

    logic [11:0] direct_in;
    logic [11:0] ptr_inc;

    // Z selects the current page (pc[11:7]) or page zero.
    assign direct_in = instr[7] ? {pc[11:7], instr[6:0]} : {5'b0, instr[6:0]};
    // 12-bit add wraps 7777 to 0000 naturally.
    assign ptr_inc   = ptr_q + 12'd1;

    always_comb begin
        state_d  = state_q;
        direct_d = direct_q;
        ptr_d    = ptr_q;
        eaddr_d  = eaddr_q;
        no_mem_d = no_mem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    direct_d = direct_in;
                    if (instr[11:9] >= 3'd6) begin
                        no_mem_d = 1'b1;
                        eaddr_d  = '0;
                        state_d  = S_DONE;
                    end else begin
                        no_mem_d = 1'b0;
                        if (!instr[8]) begin
                            eaddr_d = direct_in;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                ptr_d = mem_read_data;
                // Auto-index only reachable here, i.e. only for indirect references.
                if (direct_q >= AUTO_LO && direct_q <= AUTO_HI) begin
                    state_d = S_WB;
                end else begin
                    eaddr_d = mem_read_data;
                    state_d = S_DONE;
                end
            end
            S_WB: begin
                eaddr_d = ptr_inc;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            direct_q <= '0;
            ptr_q    <= '0;
            eaddr_q  <= '0;
            no_mem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            direct_q <= direct_d;
            ptr_q    <= ptr_d;
            eaddr_q  <= eaddr_d;
            no_mem_q <= no_mem_d;
        end
    end

    // Memory-side outputs decode straight from state so an async reset drops
    // the strobes at once rather than at the next edge.
    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        mem_read       = (state_q == S_RD);
        mem_write      = (state_q == S_WB);
        mem_address    = (mem_read || mem_write) ? direct_q : 12'd0;
        mem_write_data = mem_write ? ptr_inc : 12'd0;
        eaddr          = eaddr_q;
        no_mem         = no_mem_q;
    end

endmodule

// File: tb/tb_pdp_eaddr_unit.sv
module tb_pdp_eaddr_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] instr = '0;
    logic [11:0] pc = '0;
    logic        busy, done, no_mem, mem_read, mem_write;
    logic [11:0] eaddr, mem_address, mem_write_data;
    logic [11:0] mem_read_data = '0;

    pdp_eaddr_unit dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .pc(pc),
        .busy(busy), .done(done), .eaddr(eaddr), .no_mem(no_mem),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous 4096x12 memory with registered read data.
    logic [11:0] mem [4096];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_write_data;
        if (mem_read) mem_read_data <= mem[mem_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0o want %0o (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: plain arithmetic over a separate copy of memory.
    int ref_mem [4096];

    typedef struct {
        int eaddr;
        int no_mem;
        int lat;
        int nrd;
        int nwr;
        int maddr;
        int mval;
        int t0;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input int ins, input int p);
        exp_t e;
        int op, ind, z, off, d;
        op  = ins / 512;
        ind = (ins / 256) % 2;
        z   = (ins / 128) % 2;
        off = ins % 128;
        d   = z ? ((p / 128) * 128 + off) : off;
        e.maddr = d; e.nrd = 0; e.nwr = 0; e.no_mem = 0; e.t0 = 0;
        if (op >= 6) begin
            e.eaddr = 0; e.no_mem = 1; e.lat = 1;
        end else if (ind == 0) begin
            e.eaddr = d; e.lat = 1;
        end else if (d >= 8 && d <= 15) begin
            ref_mem[d] = (ref_mem[d] + 1) % 4096;
            e.eaddr = ref_mem[d]; e.lat = 4; e.nrd = 1; e.nwr = 1;
        end else begin
            e.eaddr = ref_mem[d]; e.lat = 3; e.nrd = 1;
        end
        e.mval = ref_mem[d];
        return e;
    endfunction

    task automatic poke(input int a, input int v);
        mem[a] = v[11:0];
        ref_mem[a] = v;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic [11:0] ins, input logic [11:0] p);
        exp_t e;
        wait_idle();
        e = model(int'(ins), int'(p));
        instr = ins; pc = p; start = 1'b1;
        @(posedge clk);
        #1;
        e.t0 = cyc;
        sb.push_back(e);
        start = 1'b0;
        // Scramble inputs to prove they were latched.
        instr = 12'($urandom);
        pc    = 12'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    // Monitor: counts strobes and scores each done pulse against the queue.
    int nrd = 0, nwr = 0, rd_addr = 0, wr_addr = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            nrd = 0; nwr = 0;
        end else begin
            if (busy) chk("rd_wr_exclusive", int'(mem_read && mem_write), 0);
            if (mem_read) begin nrd++; rd_addr = int'(mem_address); end
            if (mem_write) begin nwr++; wr_addr = int'(mem_address); end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("eaddr", int'(eaddr), e.eaddr);
                    chk("no_mem", int'(no_mem), e.no_mem);
                    chk("latency", cyc - e.t0 + 1, e.lat);
                    chk("n_read", nrd, e.nrd);
                    chk("n_write", nwr, e.nwr);
                    if (e.nrd > 0) chk("rd_addr", rd_addr, e.maddr);
                    if (e.nwr > 0) chk("wr_addr", wr_addr, e.maddr);
                    chk("mem_word", int'(mem[e.maddr]), e.mval);
                end
                nrd = 0; nwr = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved, n;
        logic [11:0] ins;
        for (int i = 0; i < 4096; i++) poke(i, int'($urandom_range(0, 4095)));
        poke(12'o0020, 12'o3456);
        poke(12'o0010, 12'o0777);
        poke(12'o0017, 12'o7777);

        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_no_mem", int'(no_mem), 0);
        chk("rst_strobes", int'({mem_read, mem_write}), 0);
        chk("rst_eaddr", int'(eaddr), 0);
        chk("rst_addr", int'(mem_address), 0);
        chk("rst_wdata", int'(mem_write_data), 0);
        @(negedge clk);
        rst = 1'b0;

        issue(12'o1205, 12'o4321);
        issue(12'o5420, 12'o1234);
        issue(12'o1410, 12'o2000);
        issue(12'o1417, 12'o0100);

        // Start pulsed during DONE must be dropped.
        issue(12'o7402, 12'o3333);
        wait_done();
        start = 1'b1; instr = 12'o1205; pc = 12'o4321;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("ignored_start_busy", int'(busy), 0);
        chk("ignored_start_done", int'(done), 0);

        // Reset during RD: strobe and busy drop at once, no write-back.
        wait_idle();
        saved = int'(mem[12'o0010]);
        instr = 12'o1410; pc = 12'o0000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("pre_rst_read", int'(mem_read), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_read", int'(mem_read), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_addr", int'(mem_address), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_write", int'(mem[12'o0010]), saved);
        issue(12'o1410, 12'o0000);

        // Random traffic, biased toward the auto-index window.
        for (int k = 0; k < 300; k++) begin
            ins = 12'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ins[7] = 1'b0;
                ins[6:0] = 7'($urandom_range(8, 15));
            end
            if ($urandom_range(0, 1) == 0) ins[8] = 1'b1;
            issue(ins, 12'($urandom));
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
